axi_lite_master_bridge: RTL
===========================

Name: axi_lite_master_bridge

Overview:
- CPU-side AXI-Lite initiator. Converts a simple single-outstanding CPU load/store request into AXI-Lite read or write transactions toward memory and peripheral slaves, such as the on-chip memory and the AXI-to-SPI bridge.
- Returns read data and a response status to the CPU as a one-cycle completion pulse.
- Supports one transaction at a time. The CPU stalls on cpu_ready.

Parameters:
- ADDR_WIDTH, 32, address width of CPU and AXI address buses.
- DATA_WIDTH, 32, data width of CPU and AXI data buses; byte strobe width is DATA_WIDTH/8.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- cpu_req  in  1  request strobe; sampled only when cpu_ready=1
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  ADDR_WIDTH  byte address, passed to AXI unmodified
- cpu_wdata  in  DATA_WIDTH  write data
- cpu_wstrb  in  DATA_WIDTH/8  write byte enables
- cpu_ready  out  1  bridge idle, request accepted this cycle if cpu_req=1
- cpu_done  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_WIDTH  read data, valid when cpu_done=1 for a read
- cpu_err  out  1  response error (xRESP[1]), valid with cpu_done
- M_AXI_AWADDR/AWVALID out, AWREADY in  write address channel
- M_AXI_WDATA/WSTRB/WVALID out, WREADY in  write data channel
- M_AXI_BRESP[1:0]/BVALID in, BREADY out  write response channel
- M_AXI_ARADDR/ARVALID out, ARREADY in  read address channel
- M_AXI_RDATA/RRESP[1:0]/RVALID in, RREADY out  read data channel

Behaviour:
- Reset values: state IDLE; all VALID and READY outputs 0; cpu_done=0; cpu_err=0; cpu_rdata=0; address and data registers 0.
- Reset is effective immediately, including mid-transaction. The bridge does not complete or replay the interrupted transaction.
- Transaction states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA. cpu_ready is 1 only in IDLE.
- IDLE + cpu_req:
  - Latch addr, wdata and wstrb.
  - If cpu_we=1, go to WR_REQ with AWVALID=1 and WVALID=1 registered from the next cycle.
  - If cpu_we=0, go to RD_REQ with ARVALID=1.
  - cpu_req while not IDLE is ignored, not queued.
- WR_REQ:
  - AWVALID and WVALID are tracked independently. Each VALID stays high with stable payload until its own READY is seen high, then drops the following cycle.
  - Handshakes may complete in either order or in the same cycle.
  - A VALID is never deasserted before its handshake.
  - Go to WR_RESP on the edge where both handshakes are complete.
- WR_RESP:
  - BREADY=1.
  - On BVALID=1, go to IDLE, pulse cpu_done on the next cycle, and set cpu_err=BRESP[1]. cpu_rdata is unchanged.
- RD_REQ:
  - ARVALID=1 with stable ARADDR until ARREADY=1, then go to RD_DATA.
- RD_DATA:
  - RREADY=1.
  - On RVALID=1, capture RDATA into cpu_rdata, set cpu_err=RRESP[1], go to IDLE, and pulse cpu_done on the next cycle.
- BREADY and RREADY are never 1 outside their response states. Responses that arrive early wait on the slave side.
- Latency with an always-ready slave that responds one cycle after the handshake: cpu_done is high exactly 3 cycles after the acceptance edge, for both reads and writes.
- cpu_done and cpu_ready=1 coincide. A new request may be accepted in the cycle cpu_done is high, giving back-to-back issue.
- cpu_err=1 for SLVERR (2'b10) and DECERR (2'b11); EXOKAY is treated as OKAY.
- cpu_rdata holds its value until the next read completes.
- No timeouts. A non-responding slave stalls the bridge until reset.

Test Plan:
- Write 0xDEADBEEF to 0x10 with wstrb=4'hF against an always-ready memory slave:
  - AWVALID and WVALID are each high 1 cycle; AWADDR=0x10.
  - BREADY is high when BVALID arrives.
  - cpu_done is high at acceptance+3 with cpu_err=0.
- Read 0x10 after that write -> ARVALID high 1 cycle; cpu_done at acceptance+3 with cpu_rdata=0xDEADBEEF and cpu_err=0.
- Skewed handshake: AWREADY delayed 3 cycles, WREADY immediate:
  - WVALID drops after 1 cycle.
  - AWVALID stays high 4 cycles with AWADDR stable.
  - BREADY rises only after the AW handshake.
  - Repeat with WREADY delayed instead, and with both delayed to the same cycle.
- Error response: slave returns BRESP=2'b10 on a write, then RRESP=2'b11 with RDATA=0x1234 on a read:
  - cpu_err=1 on both cpu_done pulses.
  - cpu_rdata=0x1234.
- Back-to-back traffic: cpu_req held high with write 0x4←0xA5A5A5A5, then read 0x4:
  - Read accepted in the same cycle as the write's cpu_done.
  - Read returns 0xA5A5A5A5.
  - cpu_req pulses during a busy state are ignored, with no extra AXI transactions.
- Reset mid-transaction: rstn low while AWVALID=1 with AWREADY held 0:
  - All VALID and READY outputs go to 0 and cpu_done=0 immediately.
  - After release, cpu_ready=1 and a fresh read completes normally.

Source files
------------

// File: rtl/axi_lite_master_bridge_if.sv
// axi_lite_master_bridge_if: AXI-Lite channel bundle between the CPU bridge and a slave
interface axi_lite_master_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_master_bridge.sv
// axi_lite_master_bridge: single-outstanding CPU load/store to AXI-Lite initiator
module axi_lite_master_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    i_cpu_req,
    input  logic                    i_cpu_we,
    input  logic [ADDR_WIDTH-1:0]   i_cpu_addr,
    input  logic [DATA_WIDTH-1:0]   i_cpu_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_cpu_wstrb,
    output logic                    o_cpu_ready,
    output logic                    o_cpu_done,
    output logic [DATA_WIDTH-1:0]   o_cpu_rdata,
    output logic                    o_cpu_err,
    axi_lite_master_bridge_if.master m_axi
);
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH/8-1:0] r_wstrb;
    logic                    r_awvalid;
    logic                    r_wvalid;
    logic                    r_done;
    logic                    r_err;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    w_accept;
    logic                    w_aw_clear;
    logic                    w_w_clear;
    logic                    w_b_hs;
    logic                    w_r_hs;

    assign w_accept   = (r_state == IDLE) && i_cpu_req;
    // A write channel counts as finished once its VALID is low or is being accepted now
    assign w_aw_clear = !r_awvalid || m_axi.awready;
    assign w_w_clear  = !r_wvalid || m_axi.wready;
    assign w_b_hs     = (r_state == WR_RESP) && m_axi.bvalid;
    assign w_r_hs     = (r_state == RD_DATA) && m_axi.rvalid;

    assign m_axi.awaddr  = r_addr;
    assign m_axi.araddr  = r_addr;
    assign m_axi.wdata   = r_wdata;
    assign m_axi.wstrb   = r_wstrb;
    assign m_axi.awvalid = r_awvalid;
    assign m_axi.wvalid  = r_wvalid;
    assign o_cpu_done    = r_done;
    assign o_cpu_err     = r_err;
    assign o_cpu_rdata   = r_rdata;

    // State register; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next state plus the handshake signals decoded straight from the state
    always_comb begin
        w_next        = r_state;
        o_cpu_ready   = 1'b0;
        m_axi.arvalid = 1'b0;
        m_axi.bready  = 1'b0;
        m_axi.rready  = 1'b0;
        case (r_state)
            IDLE: begin
                o_cpu_ready = 1'b1;
                if (i_cpu_req) w_next = i_cpu_we ? WR_REQ : RD_REQ;
            end
            WR_REQ: if (w_aw_clear && w_w_clear) w_next = WR_RESP;
            WR_RESP: begin
                m_axi.bready = 1'b1;
                if (m_axi.bvalid) w_next = IDLE;
            end
            RD_REQ: begin
                m_axi.arvalid = 1'b1;
                if (m_axi.arready) w_next = RD_DATA;
            end
            RD_DATA: begin
                m_axi.rready = 1'b1;
                if (m_axi.rvalid) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Request latch, independent AW/W VALID tracking and the CPU completion registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_done <= w_b_hs || w_r_hs;
            if (w_accept) begin
                r_addr    <= i_cpu_addr;
                r_wdata   <= i_cpu_wdata;
                r_wstrb   <= i_cpu_wstrb;
                r_awvalid <= i_cpu_we;
                r_wvalid  <= i_cpu_we;
            end else begin
                if (m_axi.awready) r_awvalid <= 1'b0;
                if (m_axi.wready)  r_wvalid  <= 1'b0;
            end
            if (w_b_hs) r_err <= m_axi.bresp >= 2'b10;
            if (w_r_hs) begin
                r_err   <= m_axi.rresp >= 2'b10;
                r_rdata <= m_axi.rdata;
            end
        end
    end
endmodule
